// File: rtl/video_dram_sched_pkg.sv
// Shared definitions for the video DRAM slot scheduler: bandwidth encodings,
// refresh defaults and the slot-type constants seen by the DRAM controller.
package video_dram_sched_pkg;

  localparam int REFRESH_AGE_DEF  = 32;
  localparam int REF_PEND_MAX_DEF = 3;

  typedef enum logic [1:0] {
    VBW_QUARTER  = 2'b00,
    VBW_HALF     = 2'b01,
    VBW_FULL     = 2'b10,
    VBW_FULL_ALT = 2'b11
  } vbw_e;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_VIDEO   = 2'd1,
    SLOT_CPU     = 2'd2,
    SLOT_REFRESH = 2'd3
  } slot_e;

  // True when a slot at phase ph may carry a video fetch in the given bandwidth mode.
  function automatic logic vbw_slot_ok(input logic [1:0] mode, input logic [1:0] ph);
    logic ok;
    case (vbw_e'(mode))
      VBW_QUARTER: ok = (ph == 2'd0);
      VBW_HALF:    ok = ~ph[0];
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/video_dram_refq.sv
// Refresh bookkeeping: pending-refresh count, wait-age with urgent flag, and the
// refresh row address that advances at the end of every refresh slot.
module video_dram_refq
  import video_dram_sched_pkg::*;
#(
  parameter int REFRESH_AGE  = REFRESH_AGE_DEF,
  parameter int REF_PEND_MAX = REF_PEND_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cend,
  input  logic       hsync_start,
  input  logic       ref_grant,
  input  logic       ref_slot_end,
  output logic       pend_nz,
  output logic       urgent,
  output logic [8:0] ref_row
);

  localparam int         AGE_W    = $clog2(REFRESH_AGE + 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(REFRESH_AGE);
  localparam logic [1:0] PEND_MAX = 2'(REF_PEND_MAX);

  logic [1:0]       ref_pend_r;
  logic [AGE_W-1:0] age_r;

  assign pend_nz = (ref_pend_r != 2'd0);
  assign urgent  = (age_r >= AGE_MAX);

  // Pending count, age and row address all advance only at DRAM cycle ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_pend_r <= 2'd0;
      age_r      <= '0;
      ref_row    <= 9'd0;
    end else if (cend) begin
      case ({hsync_start, ref_grant})
        2'b10: if (ref_pend_r != PEND_MAX) ref_pend_r <= ref_pend_r + 2'd1;
        2'b01: if (ref_pend_r != 2'd0)     ref_pend_r <= ref_pend_r - 2'd1;
        default: ref_pend_r <= ref_pend_r;
      endcase
      if (ref_grant) begin
        age_r <= '0;
      end else if (pend_nz && (age_r != AGE_MAX)) begin
        age_r <= age_r + AGE_W'(1);
      end
      // The row in use during the slot just ending is retired here.
      if (ref_slot_end) begin
        ref_row <= ref_row + 9'd1;
      end
    end
  end

endmodule

// File: rtl/video_dram_sched.sv
// Per-DRAM-cycle slot scheduler: fetch window, video phase and the
// video/refresh/CPU arbiter feeding the DRAM controller.
module video_dram_sched
  import video_dram_sched_pkg::*;
#(
  parameter int REFRESH_AGE  = REFRESH_AGE_DEF,
  parameter int REF_PEND_MAX = REF_PEND_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cend,
  input  logic       pre_cend,
  input  logic       fetch_start,
  input  logic       fetch_end,
  input  logic       hsync_start,
  input  logic       vpix,
  input  logic [1:0] mode_vbw,
  input  logic       cpu_req,
  output logic       go,
  output logic       slot_video,
  output logic       slot_cpu,
  output logic       slot_refresh,
  output logic       cpu_ack,
  output logic [8:0] ref_row,
  output logic [1:0] phase
);

  logic  start_s;
  logic  go_nxt_s;
  logic  [1:0] phase_nxt_s;
  logic  vslot_s;
  slot_e grant_s;
  logic  pend_nz_s;
  logic  urgent_s;
  logic  ref_grant_s;
  logic  unused_pre_cend;

  // Every decision is taken on cend itself, so the early strobe has no role here.
  assign unused_pre_cend = pre_cend;

  // Next window/phase state and the priority pick for the upcoming DRAM cycle.
  always_comb begin
    start_s     = fetch_start & vpix;
    go_nxt_s    = vpix & ~fetch_end & (fetch_start | go);
    phase_nxt_s = start_s ? 2'd0 : (phase + 2'd1);
    vslot_s     = go_nxt_s & vbw_slot_ok(mode_vbw, phase_nxt_s);
    grant_s     = SLOT_IDLE;
    if (vslot_s) begin
      grant_s = SLOT_VIDEO;
    end else if (urgent_s && pend_nz_s) begin
      grant_s = SLOT_REFRESH;
    end else if (cpu_req) begin
      grant_s = SLOT_CPU;
    end else if (pend_nz_s) begin
      grant_s = SLOT_REFRESH;
    end else begin
      grant_s = SLOT_IDLE;
    end
    ref_grant_s = cend & (grant_s == SLOT_REFRESH);
  end

  // Registered grants hold for a whole DRAM cycle; cpu_ack is a single-clk pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go           <= 1'b0;
      phase        <= 2'd0;
      slot_video   <= 1'b0;
      slot_cpu     <= 1'b0;
      slot_refresh <= 1'b0;
      cpu_ack      <= 1'b0;
    end else begin
      cpu_ack <= cend & (grant_s == SLOT_CPU);
      if (cend) begin
        go           <= go_nxt_s;
        phase        <= phase_nxt_s;
        slot_video   <= (grant_s == SLOT_VIDEO);
        slot_cpu     <= (grant_s == SLOT_CPU);
        slot_refresh <= (grant_s == SLOT_REFRESH);
      end
    end
  end

  video_dram_refq #(
    .REFRESH_AGE (REFRESH_AGE),
    .REF_PEND_MAX(REF_PEND_MAX)
  ) u_refq (
    .clk         (clk),
    .rst_n       (rst_n),
    .cend        (cend),
    .hsync_start (hsync_start),
    .ref_grant   (ref_grant_s),
    .ref_slot_end(slot_refresh),
    .pend_nz     (pend_nz_s),
    .urgent      (urgent_s),
    .ref_row     (ref_row)
  );

endmodule

// File: tb/tb_video_dram_sched.sv
// Directed bench for video_dram_sched: each cend is driven by a task and the
// outputs are checked on the following falling clock edge.
module tb_video_dram_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cend, pre_cend, fetch_start, fetch_end, hsync_start, vpix, cpu_req;
  logic [1:0] mode_vbw;
  logic       go, slot_video, slot_cpu, slot_refresh, cpu_ack;
  logic [8:0] ref_row;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  video_dram_sched dut (
    .clk(clk), .rst_n(rst_n), .cend(cend), .pre_cend(pre_cend),
    .fetch_start(fetch_start), .fetch_end(fetch_end), .hsync_start(hsync_start),
    .vpix(vpix), .mode_vbw(mode_vbw), .cpu_req(cpu_req),
    .go(go), .slot_video(slot_video), .slot_cpu(slot_cpu), .slot_refresh(slot_refresh),
    .cpu_ack(cpu_ack), .ref_row(ref_row), .phase(phase)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fs, input logic fe, input logic hs);
    @(negedge clk);
    pre_cend = 1'b1;
    @(negedge clk);
    pre_cend = 1'b0; cend = 1'b1; fetch_start = fs; fetch_end = fe; hsync_start = hs;
    @(negedge clk);
    cend = 1'b0; fetch_start = 1'b0; fetch_end = 1'b0; hsync_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cend = 1'b0; pre_cend = 1'b0; fetch_start = 1'b0; fetch_end = 1'b0;
    hsync_start = 1'b0; vpix = 1'b0; cpu_req = 1'b0; mode_vbw = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({go, slot_video, slot_cpu, slot_refresh, cpu_ack, phase, ref_row});
  endfunction

  initial begin
    int acks, cnt_v, cnt_r, first_r, second_r, third_r, bad;
    logic [8:0] exp_row;

    // Reset state
    do_reset();
    check("reset_outputs", all_out(), 32'd0);

    // Half bandwidth: video/cpu alternate from phase 0
    mode_vbw = 2'b01; vpix = 1'b1; cpu_req = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("vbw01_first_video", 32'(slot_video), 32'd1);
    check("vbw01_first_phase", 32'(phase), 32'd0);
    check("vbw01_go", 32'(go), 32'd1);
    acks = 0;
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (cpu_ack) acks++;
      if (slot_video !== ((i % 2) == 0) || slot_cpu !== ((i % 2) == 1) || slot_refresh !== 1'b0
          || phase !== 2'(i))
        bad++;
    end
    check("vbw01_alternation", 32'(bad), 32'd0);
    check("vbw01_ack_count", 32'(acks), 32'd4);
    @(negedge clk);
    check("cpu_ack_one_clk", 32'(cpu_ack), 32'd0);
    check("slot_cpu_held", 32'(slot_cpu), 32'd1);

    // Start and end in the same cend: window stays shut
    do_reset();
    mode_vbw = 2'b10; vpix = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("same_cend_go", 32'(go), 32'd0);
    cnt_v = 0;
    for (int i = 0; i < 4; i++) begin
      if (slot_video) cnt_v++;
      step(1'b0, 1'b0, 1'b0);
    end
    check("same_cend_no_video", 32'(cnt_v), 32'd0);

    // Full bandwidth: video beats even an urgent refresh
    do_reset();
    mode_vbw = 2'b10; vpix = 1'b1;
    cnt_v = 0; cnt_r = 0;
    for (int i = 0; i < 40; i++) begin
      step(i == 0, 1'b0, i == 1);
      if (slot_video) cnt_v++;
      if (slot_refresh) cnt_r++;
    end
    check("full_video_count", 32'(cnt_v), 32'd40);
    check("full_no_refresh", 32'(cnt_r), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("fetch_end_go", 32'(go), 32'd0);
    check("fetch_end_refresh", 32'(slot_refresh), 32'd1);
    check("refresh_row0", 32'(ref_row), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("after_refresh_idle", 32'({slot_video, slot_cpu, slot_refresh}), 32'd0);
    check("refresh_row1", 32'(ref_row), 32'd1);

    // Pending saturates at 3; urgent refresh preempts a busy CPU every 33 cends
    do_reset();
    cpu_req = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
    check("cpu_during_hsync", 32'(slot_cpu), 32'd1);
    first_r = -1; second_r = -1; third_r = -1; cnt_r = 0; bad = 0;
    for (int k = 4; k < 200; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (slot_refresh) begin
        cnt_r++;
        if (cpu_ack || slot_cpu) bad++;
        if (first_r < 0) first_r = k;
        else if (second_r < 0) second_r = k;
        else if (third_r < 0) third_r = k;
      end
    end
    check("urgent_first", 32'(first_r), 32'd33);
    check("urgent_second", 32'(second_r), 32'd66);
    check("urgent_third", 32'(third_r), 32'd99);
    check("pend_saturated_total", 32'(cnt_r), 32'd3);
    check("no_ack_on_refresh", 32'(bad), 32'd0);

    // Back-to-back refreshes walk ref_row through its wrap
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    bad = 0;
    for (int j = 1; j <= 513; j++) begin
      step(1'b0, 1'b0, 1'b1);
      exp_row = 9'(j - 1);
      if (!slot_refresh || ref_row !== exp_row) bad++;
      if (j == 512) check("row_511", 32'(ref_row), 32'd511);
      if (j == 513) check("row_wrap", 32'(ref_row), 32'd0);
    end
    check("row_sequence", 32'(bad), 32'd0);

    // Asynchronous reset in the middle of a video slot with two refreshes owed
    do_reset();
    mode_vbw = 2'b10; vpix = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("pre_reset_video", 32'(slot_video), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_out(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; vpix = 1'b0;
    cnt_r = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (slot_refresh) cnt_r++;
    end
    check("pend_cleared_by_reset", 32'(cnt_r), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("hsync_cend_no_refresh", 32'(slot_refresh), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("refresh_after_hsync", 32'(slot_refresh), 32'd1);
    check("refresh_after_reset_row", 32'(ref_row), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_dram_sched.md
Name: video_dram_sched

Overview:
- Per-DRAM-cycle slot scheduler for the 7 MHz video timebase.
- Opens and closes the video fetch window ('go') from the horizontal sync generator's fetch strobes.
- Assigns each DRAM cycle (one per cend) to exactly one of: video fetch, CPU access, DRAM refresh, or idle.
- Sits between the horizontal/vertical sync generators and the DRAM controller.

Parameters:
- REFRESH_AGE, 32, cend cycles a pending refresh may wait before it overrides CPU.
- REF_PEND_MAX, 3, saturation value of the pending-refresh counter (2-bit).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cend  in  1  DRAM cycle end strobe, one clk wide
- pre_cend  in  1  strobe one clk before cend
- fetch_start  in  1  pulse coincident with cend: open fetch window
- fetch_end  in  1  pulse coincident with cend: close fetch window
- hsync_start  in  1  pulse coincident with cend: one refresh request per line
- vpix  in  1  vertical pixel gate
- mode_vbw  in  2  video bandwidth: 00=1/4, 01=2/4, 10=4/4, 11=same as 10
- cpu_req  in  1  CPU DRAM request, level, held until cpu_ack
- go  out  1  video fetch window
- slot_video  out  1  current DRAM cycle granted to video
- slot_cpu  out  1  current DRAM cycle granted to CPU
- slot_refresh  out  1  current DRAM cycle granted to refresh
- cpu_ack  out  1  one-clk pulse, CPU grant accepted
- ref_row  out  9  refresh row address for the current refresh slot
- phase  out  2  slot phase within the 4-cycle video group

Behaviour:
- Reset values: all outputs 0. Also cleared: ref_pend, age counter, ref_row. Reset is asynchronous and may assert at any clk; deassertion resumes from the all-zero state at the next cend.
- All state updates only on clk edges where cend=1, except cpu_ack.
- go:
  - Set when fetch_start & vpix.
  - Cleared when fetch_end, or when vpix=0.
  - fetch_start and fetch_end in the same cend: clear wins.
- phase:
  - Increments mod 4 each cend.
  - Forced to 0 on the cend carrying fetch_start & vpix, so the first video slot is at phase 0.
- Video-eligible slot in the next cycle (vslot), only while the next go=1:
  - mode_vbw=00: next phase==0.
  - mode_vbw=01: next phase[0]==0.
  - mode_vbw=1x: every cycle.
- ref_pend (2-bit): +1 on hsync_start, −1 on refresh grant; simultaneous +1/−1 leaves it unchanged; saturates at REF_PEND_MAX, never below 0.
- Age counter:
  - Counts cend cycles while ref_pend≠0 and no refresh is granted; reset to 0 on refresh grant.
  - urgent = (age ≥ REFRESH_AGE).
  - Counter saturates and does not wrap.
- Grant priority, evaluated every cend, registered, one-hot or all-zero:
  1. vslot → video.
  2. urgent & ref_pend≠0 → refresh.
  3. cpu_req → cpu.
  4. ref_pend≠0 → refresh.
  5. else idle.
- Grant outputs hold for the whole following DRAM cycle, until the next cend.
- cpu_ack: one-clk pulse on the same edge that sets slot_cpu. cpu_req sampled high on that cend is considered served; a still-high cpu_req at the next cend is a new request.
- ref_row increments (9-bit wrap, 511→0) on the cend ending a refresh slot, so each refresh uses the current value and then advances.
- mode_vbw change mid-line takes effect at the next cend; no glitch in the one-hot grant.
- Latency: request sampled at cend N → grant visible from clk after cend N through cend N+1.

Decomposition:
- Shared video package: mode_vbw encodings, REFRESH_AGE default, and a slot-type constant set (IDLE, VIDEO, CPU, REFRESH) for the DRAM controller.
- One natural sub-module, video_dram_refq: ref_pend counter, age counter, urgent flag and ref_row.
- Window/phase logic and the arbiter stay in the top module.

Test Plan:
- mode_vbw=01, vpix=1, fetch_start then 8 cend, cpu_req=1 throughout → slots alternate video/cpu starting with video at phase 0; 4 cpu_ack pulses.
- fetch_start and fetch_end in the same cend → go stays 0; no video slots follow.
- mode_vbw=10, go=1 for 40 cend, one hsync_start → refresh never granted while go=1 (vslot beats urgent); first free slot after fetch_end is refresh; ref_row 0→1.
- go=0, cpu_req=1 continuously, 4 hsync_start pulses → ref_pend saturates at 3; after 32 cend one refresh preempts CPU; age resets to 0.
- ref_row preset via 512 refresh grants → wraps 511→0.
- rst_n low mid-video-slot with ref_pend=2 → all outputs 0 asynchronously; after release, no refresh until the next hsync_start.
